// File: rtl/ahb_crypto_pkg.sv
// Shared constants, FSM state type and helpers for the multi-channel crypto AHB slave.
package ahb_crypto_pkg;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_NONE   = 2'd3;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam int CTRL_ENC = 0;
  localparam int CTRL_DEC = 1;
  localparam int CTRL_KEY = 2;

  typedef enum logic [2:0] {IDLE, DATA, WAIT, ERR1, ERR2} state_t;

  // A single channel still needs a one-bit channel field.
  function automatic int chWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ahb_mc_decode.sv
// Address-phase decode: pulls out channel and register offset and flags illegal accesses.
module ahb_mc_decode
  import ahb_crypto_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32,
  parameter int CH_W   = 1
) (
  input  logic [4+CH_W-1:0] i_addr,
  input  logic [2:0]        i_size,
  input  logic              i_write,
  output logic [CH_W-1:0]   o_ch,
  output logic [1:0]        o_off,
  output logic              o_err
);

  localparam logic [2:0] SIZE_OK = 3'($clog2(DATA_W / 8));

  assign o_ch  = i_addr[4 +: CH_W];
  assign o_off = i_addr[3:2];

  // STATUS is read-only and CTRL write-only, so the wrong direction is an error too.
  assign o_err = (int'(o_ch) >= NUM_CH)
               | (o_off == OFF_NONE)
               | (i_addr[1:0] != 2'b00)
               | (i_size != SIZE_OK)
               | (i_write & (o_off == OFF_STATUS))
               | (~i_write & (o_off == OFF_CTRL));

endmodule

// File: rtl/ahb_crypto_mc_slave.sv
// AHB-Lite slave fronting NUM_CH cipher channels: FIFO data port, status byte and control pulses.
module ahb_crypto_mc_slave
  import ahb_crypto_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     HSELx,
  input  logic [31:0]              HADDR,
  input  logic [1:0]               HTRANS,
  input  logic [2:0]               HSIZE,
  input  logic                     HWRITE,
  input  logic [DATA_W-1:0]        HWDATA,
  input  logic                     HREADY,
  input  logic [NUM_CH*DATA_W-1:0] data_out,
  input  logic [NUM_CH*8-1:0]      status,
  input  logic [NUM_CH-1:0]        rcv_fifo_full,
  input  logic [NUM_CH-1:0]        tx_fifo_empty,
  output logic [DATA_W-1:0]        HRDATA,
  output logic                     HREADYOUT,
  output logic [1:0]               HRESP,
  output logic [DATA_W-1:0]        rcv_data,
  output logic [NUM_CH-1:0]        rcv_enq_word,
  output logic [NUM_CH-1:0]        tx_deq_word,
  output logic [NUM_CH-1:0]        is_encrypt_pulse,
  output logic [NUM_CH-1:0]        is_decrypt_pulse,
  output logic [NUM_CH-1:0]        key_in
);

  localparam int CH_W = chWidth(NUM_CH);

  state_t             r_state, w_nextState;
  logic [CH_W-1:0]    r_ch, w_decCh;
  logic [1:0]         r_off, w_decOff;
  logic               r_write, r_err, w_decErr;
  logic [NUM_CH*8-1:0] r_status;
  logic [NUM_CH-1:0]  r_encPulse, r_decPulse, r_keyPulse;
  logic [NUM_CH-1:0]  w_chHot;
  logic               w_accept, w_capture, w_blocked, w_ctrlBad, w_fault, w_done;
  logic               w_full, w_empty, w_ctrlWrite;
  logic [DATA_W-1:0]  w_txHead;
  logic [7:0]         w_statByte;

  ahb_mc_decode #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_W(CH_W)) u_decode (
    .i_addr  (HADDR[4+CH_W-1:0]),
    .i_size  (HSIZE),
    .i_write (HWRITE),
    .o_ch    (w_decCh),
    .o_off   (w_decOff),
    .o_err   (w_decErr)
  );

  // Loop-based select keeps an out-of-range channel from indexing past the vectors.
  always_comb begin
    w_chHot    = '0;
    w_full     = 1'b0;
    w_empty    = 1'b0;
    w_txHead   = '0;
    w_statByte = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(r_ch) == i) begin
        w_chHot[i] = 1'b1;
        w_full     = rcv_fifo_full[i];
        w_empty    = tx_fifo_empty[i];
        w_txHead   = data_out[i*DATA_W +: DATA_W];
        w_statByte = r_status[i*8 +: 8];
      end
    end
  end

  assign w_accept    = HSELx & HREADY & HTRANS[1];
  assign w_blocked   = (r_off == OFF_DATA) & (r_write ? w_full : w_empty);
  assign w_ctrlBad   = r_write & (r_off == OFF_CTRL) & HWDATA[CTRL_ENC] & HWDATA[CTRL_DEC];
  assign w_fault     = r_err | w_ctrlBad;
  assign w_ctrlWrite = w_done & r_write & (r_off == OFF_CTRL);

  always_comb begin
    w_nextState = r_state;
    w_done      = 1'b0;
    HREADYOUT   = 1'b1;
    HRESP       = HRESP_OKAY;
    unique case (r_state)
      IDLE: ;
      DATA: begin
        w_done    = ~w_fault & ~w_blocked;
        HREADYOUT = w_done;
      end
      WAIT: begin
        w_done    = ~w_blocked;
        HREADYOUT = w_done;
      end
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      ERR2: HRESP = HRESP_ERROR;
      default: ;
    endcase
    w_capture = w_accept & HREADYOUT;
    unique case (r_state)
      IDLE: if (w_capture) w_nextState = DATA;
      DATA: begin
        if (w_fault)        w_nextState = ERR1;
        else if (w_blocked) w_nextState = WAIT;
        else                w_nextState = w_capture ? DATA : IDLE;
      end
      WAIT: if (!w_blocked) w_nextState = w_capture ? DATA : IDLE;
      ERR1: w_nextState = ERR2;
      ERR2: w_nextState = w_capture ? DATA : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= IDLE;
      r_ch    <= '0;
      r_off   <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_capture) begin
        r_ch    <= w_decCh;
        r_off   <= w_decOff;
        r_write <= HWRITE;
        r_err   <= w_decErr;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_status   <= '0;
      r_encPulse <= '0;
      r_decPulse <= '0;
      r_keyPulse <= '0;
    end else begin
      r_status   <= status;
      r_encPulse <= w_ctrlWrite ? (w_chHot & {NUM_CH{HWDATA[CTRL_ENC]}}) : '0;
      r_decPulse <= w_ctrlWrite ? (w_chHot & {NUM_CH{HWDATA[CTRL_DEC]}}) : '0;
      r_keyPulse <= w_ctrlWrite ? (w_chHot & {NUM_CH{HWDATA[CTRL_KEY]}}) : '0;
    end
  end

  assign is_encrypt_pulse = r_encPulse;
  assign is_decrypt_pulse = r_decPulse;
  assign key_in           = r_keyPulse;

  assign rcv_enq_word = (w_done & r_write & (r_off == OFF_DATA))  ? w_chHot : '0;
  assign tx_deq_word  = (w_done & ~r_write & (r_off == OFF_DATA)) ? w_chHot : '0;
  assign rcv_data     = (|rcv_enq_word) ? HWDATA : '0;

  always_comb begin
    HRDATA = '0;
    if (w_done & ~r_write)
      HRDATA = (r_off == OFF_DATA) ? w_txHead : DATA_W'(w_statByte);
  end

endmodule
